spike_event_arbiter: RTL and testbench

Collects one-cycle spikes from a bank of spiking neurons and sends them, one at a time, onto a shared spike-event channel with a valid/ready handshake. Each spike is latched as a pending flag. A round-robin arbiter picks one pending flag per free output slot and emits the winner's neuron index. The block sits between a layer of `spiking_neuron_2in` instances and the downstream router/logger, so simultaneous firings are serialized without loss up to one outstanding spike per neuron.

---
 rtl/spike_event_if.sv | 25 ++
 rtl/spike_event_arbiter.sv | 139 +++++++++++++
 tb/tb_spike_event_arbiter.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/spike_event_if.sv
// Spike-event channel between the arbiter and its neighbours: spike inputs, flush,
// the valid/ready event handshake and status outputs.
interface spike_event_if #(
  parameter int N_NEURONS = 4,
  parameter int ID_WIDTH  = 2,
  parameter int CNT_WIDTH = 8
);
  logic [N_NEURONS-1:0] spike_in;
  logic                 flush;
  logic                 ev_ready;
  logic                 ev_valid;
  logic [ID_WIDTH-1:0]  ev_id;
  logic [CNT_WIDTH-1:0] drop_count;
  logic                 busy;

  modport master (
    output spike_in, flush, ev_ready,
    input  ev_valid, ev_id, drop_count, busy
  );

  modport slave (
    input  spike_in, flush, ev_ready,
    output ev_valid, ev_id, drop_count, busy
  );
endinterface

// File: rtl/spike_event_arbiter.sv
// Latches one-cycle neuron spikes as pending flags and serializes them round-robin
// onto a valid/ready event channel, counting spikes lost to an already-pending flag.
module spike_event_arbiter #(
  parameter int N_NEURONS = 4,
  parameter int ID_WIDTH  = 2,
  parameter int CNT_WIDTH = 8
) (
  input logic           clk,
  input logic           rst,
  spike_event_if.slave  bus
);

  typedef enum logic [0:0] {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  state_t               state_r;
  state_t               state_next_s;
  logic [N_NEURONS-1:0] pending_r;
  logic [N_NEURONS-1:0] pending_next_s;
  logic [N_NEURONS-1:0] grant_vec_s;
  logic [N_NEURONS-1:0] drop_vec_s;
  logic [ID_WIDTH-1:0]  ev_id_r;
  logic [ID_WIDTH-1:0]  last_grant_r;
  logic [ID_WIDTH-1:0]  grant_idx_s;
  logic [ID_WIDTH:0]    cand_s;
  logic [CNT_WIDTH-1:0] drop_count_r;
  logic [CNT_WIDTH-1:0] drop_next_s;
  logic [CNT_WIDTH:0]   drop_sum_s;
  logic                 found_s;
  logic                 slot_free_s;
  logic                 grant_s;

  function automatic logic [CNT_WIDTH:0] count_ones(input logic [N_NEURONS-1:0] v);
    logic [CNT_WIDTH:0] c;
    c = {(CNT_WIDTH+1){1'b0}};
    for (int i = 0; i < N_NEURONS; i++) begin
      c = c + {{CNT_WIDTH{1'b0}}, v[i]};
    end
    return c;
  endfunction

  // Round-robin scan of registered pending flags, starting just after last_grant.
  always_comb begin
    found_s     = 1'b0;
    grant_idx_s = {ID_WIDTH{1'b0}};
    cand_s      = {(ID_WIDTH+1){1'b0}};
    for (int k = 1; k <= N_NEURONS; k++) begin
      cand_s = {1'b0, last_grant_r} + (ID_WIDTH+1)'(k);
      if (cand_s >= (ID_WIDTH+1)'(N_NEURONS)) begin
        cand_s = cand_s - (ID_WIDTH+1)'(N_NEURONS);
      end else begin
        cand_s = cand_s;
      end
      if (!found_s && pending_r[cand_s[ID_WIDTH-1:0]]) begin
        found_s     = 1'b1;
        grant_idx_s = cand_s[ID_WIDTH-1:0];
      end else begin
        found_s = found_s;
      end
    end
  end

  // Slot/grant decision, pending update and saturating drop accounting.
  always_comb begin
    slot_free_s = (state_r == ST_EMPTY) || bus.ev_ready;
    grant_s     = slot_free_s && found_s && !bus.flush;
    for (int i = 0; i < N_NEURONS; i++) begin
      grant_vec_s[i] = grant_s && (grant_idx_s == ID_WIDTH'(i));
    end
    if (bus.flush) begin
      pending_next_s = {N_NEURONS{1'b0}};
      drop_vec_s     = {N_NEURONS{1'b0}};
    end else begin
      // A granted bit re-spiking on its grant edge is re-captured, not dropped.
      pending_next_s = (pending_r & ~grant_vec_s) | bus.spike_in;
      drop_vec_s     = bus.spike_in & pending_r & ~grant_vec_s;
    end
    drop_sum_s = {1'b0, drop_count_r} + count_ones(drop_vec_s);
    if (drop_sum_s[CNT_WIDTH]) begin
      drop_next_s = {CNT_WIDTH{1'b1}};
    end else begin
      drop_next_s = drop_sum_s[CNT_WIDTH-1:0];
    end
  end

  // Output slot next-state: EMPTY/FULL mirrors ev_valid.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_EMPTY: begin
        if (grant_s) begin
          state_next_s = ST_FULL;
        end else begin
          state_next_s = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (bus.flush) begin
          state_next_s = ST_EMPTY;
        end else if (bus.ev_ready && !grant_s) begin
          state_next_s = ST_EMPTY;
        end else begin
          state_next_s = ST_FULL;
        end
      end
      default: state_next_s = ST_EMPTY;
    endcase
  end

  // State registers; async reset leaves last_grant so index 0 wins first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= ST_EMPTY;
      pending_r    <= {N_NEURONS{1'b0}};
      ev_id_r      <= {ID_WIDTH{1'b0}};
      last_grant_r <= ID_WIDTH'(N_NEURONS - 1);
      drop_count_r <= {CNT_WIDTH{1'b0}};
    end else begin
      state_r      <= state_next_s;
      pending_r    <= pending_next_s;
      drop_count_r <= drop_next_s;
      if (grant_s) begin
        ev_id_r      <= grant_idx_s;
        last_grant_r <= grant_idx_s;
      end else begin
        ev_id_r      <= ev_id_r;
        last_grant_r <= last_grant_r;
      end
    end
  end

  assign bus.ev_valid   = (state_r == ST_FULL);
  assign bus.ev_id      = ev_id_r;
  assign bus.drop_count = drop_count_r;
  assign bus.busy       = (|pending_r) || (state_r == ST_FULL);

endmodule

// File: tb/tb_spike_event_arbiter.sv
// Directed bench for spike_event_arbiter with hand-computed expected events,
// drop counts and flush/reset behaviour.
module tb_spike_event_arbiter;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  spike_event_if #(.N_NEURONS(4), .ID_WIDTH(2), .CNT_WIDTH(8)) ev_bus ();

  spike_event_arbiter #(.N_NEURONS(4), .ID_WIDTH(2), .CNT_WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ev_bus)
  );

  // Rising edges at 20, 40, 60 ns ...
  initial clk = 1'b1;
  always #10 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic expect_ev(input string tag, input logic v, input logic [1:0] id);
    check({tag, "_valid"}, 32'(ev_bus.ev_valid), 32'(v));
    if (v) check({tag, "_id"}, 32'(ev_bus.ev_id), 32'(id));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b1;
    ev_bus.spike_in = 4'b0000;
    ev_bus.flush    = 1'b0;
    ev_bus.ev_ready = 1'b0;
    #30;
    rst = 1'b0;
    check("rst_valid", 32'(ev_bus.ev_valid), 32'd0);
    check("rst_id",    32'(ev_bus.ev_id),    32'd0);
    check("rst_drop",  32'(ev_bus.drop_count), 32'd0);
    check("rst_busy",  32'(ev_bus.busy),     32'd0);

    // Round robin from reset: 0,1,2,3 then wrap 0,1
    ev_bus.ev_ready = 1'b1;
    ev_bus.spike_in = 4'b1111;
    step(); ev_bus.spike_in = 4'b0000;
    expect_ev("rr_cap", 1'b0, 2'd0);
    step(); expect_ev("rr_e0", 1'b1, 2'd0);
    step(); expect_ev("rr_e1", 1'b1, 2'd1);
    step(); expect_ev("rr_e2", 1'b1, 2'd2);
    step(); expect_ev("rr_e3", 1'b1, 2'd3);
    ev_bus.spike_in = 4'b0011;
    step(); ev_bus.spike_in = 4'b0000;
    expect_ev("rr_gap", 1'b0, 2'd0);
    step(); expect_ev("rr_w0", 1'b1, 2'd0);
    step(); expect_ev("rr_w1", 1'b1, 2'd1);
    step(); expect_ev("rr_end", 1'b0, 2'd0);

    // Single spike on neuron 2
    ev_bus.spike_in = 4'b0100;
    step(); ev_bus.spike_in = 4'b0000;
    expect_ev("single_cap", 1'b0, 2'd0);
    check("single_busy1", 32'(ev_bus.busy), 32'd1);
    step(); expect_ev("single_ev", 1'b1, 2'd2);
    step(); expect_ev("single_end", 1'b0, 2'd0);
    check("single_busy0", 32'(ev_bus.busy), 32'd0);
    check("single_drop", 32'(ev_bus.drop_count), 32'd0);

    // Async reset mid-burst, then first grant is index 0
    ev_bus.spike_in = 4'b1111;
    step(); ev_bus.spike_in = 4'b0000;
    step(); expect_ev("burst_e3", 1'b1, 2'd3);
    #5 rst = 1'b1;
    #1;
    check("arst_valid", 32'(ev_bus.ev_valid), 32'd0);
    check("arst_id",    32'(ev_bus.ev_id),    32'd0);
    check("arst_busy",  32'(ev_bus.busy),     32'd0);
    #2 rst = 1'b0;
    ev_bus.spike_in = 4'b1001;
    step(); ev_bus.spike_in = 4'b0000;
    step(); expect_ev("post_rst_e0", 1'b1, 2'd0);
    step(); expect_ev("post_rst_e3", 1'b1, 2'd3);
    step(); expect_ev("post_rst_end", 1'b0, 2'd0);

    // Back-pressure: id 1 held for 5 cycles, then 1 -> 2
    ev_bus.ev_ready = 1'b0;
    ev_bus.spike_in = 4'b0110;
    step(); ev_bus.spike_in = 4'b0000;
    step(); expect_ev("bp_first", 1'b1, 2'd1);
    for (int i = 0; i < 5; i++) begin
      step(); expect_ev("bp_hold", 1'b1, 2'd1);
    end
    ev_bus.ev_ready = 1'b1;
    step(); expect_ev("bp_next", 1'b1, 2'd2);
    step(); expect_ev("bp_end", 1'b0, 2'd0);

    // Drop: neuron 1 pending while neuron 0 is presented
    ev_bus.ev_ready = 1'b0;
    ev_bus.spike_in = 4'b0011;
    step(); ev_bus.spike_in = 4'b0000;
    step(); expect_ev("drop_pres", 1'b1, 2'd0);
    ev_bus.spike_in = 4'b0010;
    step(); ev_bus.spike_in = 4'b0000;
    check("drop_one", 32'(ev_bus.drop_count), 32'd1);
    ev_bus.ev_ready = 1'b1;
    step(); expect_ev("drop_drain", 1'b1, 2'd1);

    // Re-spike of neuron 2 on its grant edge: emitted twice, no drop
    ev_bus.spike_in = 4'b0100;
    step(); expect_ev("resp_cap", 1'b0, 2'd0);
    step(); ev_bus.spike_in = 4'b0000;
    expect_ev("resp_e1", 1'b1, 2'd2);
    check("resp_drop", 32'(ev_bus.drop_count), 32'd1);
    step(); expect_ev("resp_e2", 1'b1, 2'd2);
    step(); expect_ev("resp_end", 1'b0, 2'd0);
    check("resp_drop_end", 32'(ev_bus.drop_count), 32'd1);

    // Multi-bit drops in one edge, then saturation
    ev_bus.ev_ready = 1'b0;
    ev_bus.spike_in = 4'b0011;
    step(); ev_bus.spike_in = 4'b1110;
    step(); expect_ev("sat_pres", 1'b1, 2'd0);
    check("sat_drop2", 32'(ev_bus.drop_count), 32'd2);
    step();
    check("sat_drop5", 32'(ev_bus.drop_count), 32'd5);
    for (int i = 0; i < 100; i++) step();
    ev_bus.spike_in = 4'b0000;
    check("sat_255", 32'(ev_bus.drop_count), 32'd255);
    step();
    check("sat_hold", 32'(ev_bus.drop_count), 32'd255);

    // Flush clears pending/valid, keeps ev_id, drop_count and last_grant
    ev_bus.flush = 1'b1;
    step(); ev_bus.flush = 1'b0;
    expect_ev("fl0", 1'b0, 2'd0);
    check("fl0_busy", 32'(ev_bus.busy), 32'd0);
    check("fl0_id",   32'(ev_bus.ev_id), 32'd0);
    ev_bus.spike_in = 4'b1011;
    step(); ev_bus.spike_in = 4'b0000;
    step(); expect_ev("fl_pres", 1'b1, 2'd1);
    ev_bus.flush    = 1'b1;
    ev_bus.spike_in = 4'b0100;
    step(); ev_bus.flush = 1'b0; ev_bus.spike_in = 4'b0000;
    check("fl_valid", 32'(ev_bus.ev_valid), 32'd0);
    check("fl_busy",  32'(ev_bus.busy),     32'd0);
    check("fl_id",    32'(ev_bus.ev_id),    32'd1);
    check("fl_drop",  32'(ev_bus.drop_count), 32'd255);
    ev_bus.ev_ready = 1'b1;
    ev_bus.spike_in = 4'b1001;
    step(); ev_bus.spike_in = 4'b0000;
    step(); expect_ev("fl_lg_e3", 1'b1, 2'd3);
    step(); expect_ev("fl_lg_e0", 1'b1, 2'd0);
    step(); expect_ev("fl_lg_end", 1'b0, 2'd0);

    // Async reset clears a saturated counter; first grant is index 0
    ev_bus.spike_in = 4'b1111;
    step(); ev_bus.spike_in = 4'b0000;
    step(); expect_ev("rst2_e1", 1'b1, 2'd1);
    #5 rst = 1'b1;
    #1;
    check("rst2_valid", 32'(ev_bus.ev_valid), 32'd0);
    check("rst2_drop",  32'(ev_bus.drop_count), 32'd0);
    check("rst2_busy",  32'(ev_bus.busy),     32'd0);
    #2 rst = 1'b0;
    ev_bus.spike_in = 4'b0111;
    step(); ev_bus.spike_in = 4'b0000;
    step(); expect_ev("rst2_g0", 1'b1, 2'd0);
    step(); expect_ev("rst2_g1", 1'b1, 2'd1);
    step(); expect_ev("rst2_g2", 1'b1, 2'd2);
    step(); expect_ev("rst2_end", 1'b0, 2'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
